// File: rtl/multiplier_control.sv
// multiplier_control: sequencer for a shift-and-add multiplier (load, add/shift per bit, done)
module multiplier_control #(
   parameter int WIDTH = 32,
   parameter int CW    = 6
) (
   input  logic          clk,
   input  logic          Reset,
   input  logic          Run,
   input  logic          LSB,
   output logic          W_ctrl,
   output logic          ADD_ctrl,
   output logic          SRL_ctrl,
   output logic          Busy,
   output logic          Ready,
   output logic [CW-1:0] Count
);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] count_nxt;
   // state and iteration counter, cleared asynchronously so a reset aborts any operation at once
   always_ff @(posedge clk or negedge Reset)
      if (!Reset) begin
         state <= IDLE;
         Count <= '0;
      end else begin
         state <= state_nxt;
         Count <= count_nxt;
      end
   // next state, counter update and Moore/Mealy outputs; LSB only reaches an output in ADD
   always_comb begin
      state_nxt = state;
      count_nxt = Count;
      W_ctrl    = 1'b0;
      ADD_ctrl  = 1'b0;
      SRL_ctrl  = 1'b0;
      Busy      = 1'b0;
      Ready     = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = Run ? LOAD : IDLE;
            count_nxt = Run ? '0 : Count;
         end
         LOAD: begin
            W_ctrl    = 1'b1;
            Busy      = 1'b1;
            state_nxt = ADD;
            count_nxt = '0;
         end
         ADD: begin
            ADD_ctrl  = LSB;
            Busy      = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            SRL_ctrl  = 1'b1;
            Busy      = 1'b1;
            state_nxt = (Count == LAST) ? DONE : ADD;
            count_nxt = (Count == LAST) ? Count : Count + 1'b1;
         end
         DONE: begin
            Ready     = 1'b1;
            state_nxt = Run ? LOAD : DONE;
            count_nxt = Run ? '0 : Count;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_multiplier_control.sv
// tb_multiplier_control: randomized bench against a cycle-count reference model of the multiply sequence
module tb_multiplier_control;
   localparam int W = 32;
   localparam int LAT = 2 * W + 1;
   logic clk = 1'b0, Reset = 1'b0, Run = 1'b0, LSB = 1'b0;
   logic W_ctrl, ADD_ctrl, SRL_ctrl, Busy, Ready;
   logic [5:0] Count;
   int n_chk = 0, n_pass = 0;
   // reference model: an operation is a run of LAT cycles counted from the accepting edge
   bit m_run = 0, m_done = 0;
   int m_t = 0, m_cnt = 0;
   // per-operation tallies
   int cyc = 0, acc_cyc = 0, w_cnt = 0, srl_cnt = 0, add_cnt = 0, ones_fed = 0;
   bit prev_ready = 0;
   int lsb_mode = 0;
   bit xmode = 0;
   logic [31:0] pat = 32'h0;

   multiplier_control #(.WIDTH(W), .CW(6)) dut (
      .clk(clk), .Reset(Reset), .Run(Run), .LSB(LSB),
      .W_ctrl(W_ctrl), .ADD_ctrl(ADD_ctrl), .SRL_ctrl(SRL_ctrl),
      .Busy(Busy), .Ready(Ready), .Count(Count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic bit in_add();
      return m_run && (m_t % 2 == 1);
   endfunction

   task automatic check_outputs();
      check("W_ctrl", 32'(W_ctrl), 32'(m_run && m_t == 0));
      check("ADD_ctrl", 32'(ADD_ctrl), 32'(in_add() && LSB === 1'b1));
      check("SRL_ctrl", 32'(SRL_ctrl), 32'(m_run && m_t > 0 && m_t % 2 == 0));
      check("Busy", 32'(Busy), 32'(m_run));
      check("Ready", 32'(Ready), 32'(m_done));
      check("Count", 32'(Count), 32'(m_cnt));
   endtask

   task automatic model_clear();
      m_run = 0; m_done = 0; m_t = 0; m_cnt = 0; prev_ready = 0;
   endtask

   // one clock: Run applied at the falling edge, model advanced at the rising edge, LSB then chosen
   task automatic tick(input logic run);
      @(negedge clk);
      Run = run;
      @(posedge clk);
      cyc++;
      if (!Reset) model_clear();
      else if (!m_run) begin
         if (run) begin
            m_run = 1; m_done = 0; m_t = 0; m_cnt = 0;
            acc_cyc = cyc; w_cnt = 0; srl_cnt = 0; add_cnt = 0; ones_fed = 0;
         end
      end else begin
         m_t++;
         if (m_t == LAT) begin m_run = 0; m_done = 1; end
         else m_cnt = (m_t - 1) / 2;
      end
      #1;
      if (in_add()) LSB = (lsb_mode == 1) ? pat[(m_t - 1) / 2] : (lsb_mode == 2) ? 1'b0 : 1'($urandom);
      else LSB = xmode ? 1'bx : 1'($urandom);
      #1;
      check_outputs();
      w_cnt += int'(W_ctrl === 1'b1);
      srl_cnt += int'(SRL_ctrl === 1'b1);
      add_cnt += int'(ADD_ctrl === 1'b1);
      ones_fed += int'(in_add() && LSB === 1'b1);
      if (Ready === 1'b1 && !prev_ready) begin
         check("latency", 32'(cyc - acc_cyc), 32'(LAT));
         check("w_pulses", 32'(w_cnt), 32'd1);
         check("srl_pulses", 32'(srl_cnt), 32'(W));
         check("add_pulses", 32'(add_cnt), 32'(ones_fed));
      end
      prev_ready = (Ready === 1'b1);
   endtask

   // asynchronous reset asserted between edges; outputs must clear without a clock
   task automatic mid_reset();
      #1 Reset = 1'b0;
      #1;
      check("rst_W", 32'(W_ctrl), 32'd0);
      check("rst_ADD", 32'(ADD_ctrl), 32'd0);
      check("rst_SRL", 32'(SRL_ctrl), 32'd0);
      check("rst_Busy", 32'(Busy), 32'd0);
      check("rst_Ready", 32'(Ready), 32'd0);
      check("rst_Count", 32'(Count), 32'd0);
      model_clear();
      Reset = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0);
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 3; i++) tick(1'b0);
      Reset = 1'b1;
      idle(10);
      // multiplier 0x0000000B: adds in iterations 0, 1 and 3
      lsb_mode = 1; pat = 32'h0000000B;
      tick(1'b1);
      idle(LAT + 2);
      check("add_pulses_0xB", 32'(add_cnt), 32'd3);
      // Run held high: restart from DONE, Ready for a single cycle
      lsb_mode = 0;
      for (int i = 0; i < 2 * LAT + 5; i++) tick(1'b1);
      idle(LAT + 2);
      // LSB zero in ADD, X elsewhere
      lsb_mode = 2; xmode = 1;
      tick(1'b1);
      idle(LAT + 2);
      check("add_pulses_zero", 32'(add_cnt), 32'd0);
      xmode = 0; lsb_mode = 0;
      // abort at iteration 10 in SHIFT
      tick(1'b1);
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick(1'b0);
         found = m_run && m_t > 0 && m_t % 2 == 0 && m_cnt == 10;
      end
      check("reached_iter10", 32'(found), 32'd1);
      mid_reset();
      idle(5);
      check("no_pulses_after_rst", 32'(w_cnt + srl_cnt), 32'(srl_cnt + 1));
      // Run at the first edge after release is accepted
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      mid_reset();
      tick(1'b1);
      idle(LAT + 2);
      // Run toggled randomly while busy
      tick(1'b1);
      for (int i = 0; i < LAT - 1; i++) tick(1'($urandom));
      idle(4);
      // random multiplies with random gaps
      for (int k = 0; k < 4; k++) begin
         idle($urandom_range(0, 3));
         tick(1'b1);
         idle(LAT + 1);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/multiplier_control.md
MULTIPLIER_CONTROL -- requirements
Module: multiplier_control

Interface
REQ-001 Parameter: WIDTH, 32, operand width; number of add/shift iterations per multiply.
REQ-002 Parameter: CW, 6, width of the iteration counter; SHALL satisfy 2^CW > WIDTH.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: Reset  input  1  asynchronous, active-low reset.
REQ-005 Port: Run  input  1  start request; sampled only in IDLE or DONE.
REQ-006 Port: LSB  input  1  bit 0 of the product register (current multiplier bit).
REQ-007 Port: W_ctrl  output  1  loads the multiplier into the low half of the product register.
REQ-008 Port: ADD_ctrl  output  1  writes the ALU sum into the high half of the product register.
REQ-009 Port: SRL_ctrl  output  1  shifts the product register right by 1.
REQ-010 Port: Busy  output  1  an operation is in progress (LOAD, ADD or SHIFT).
REQ-011 Port: Ready  output  1  result valid; held until the next accepted Run or reset.
REQ-012 Port: Count  output  CW  index of the iteration in progress, 0..WIDTH-1.

Function
REQ-013 The FSM SHALL have five states: IDLE, LOAD, ADD, SHIFT, DONE.
REQ-014 IDLE: Run=1 -> LOAD; otherwise stay in IDLE.
REQ-015 LOAD: W_ctrl=1 for exactly one cycle, Count cleared to 0; unconditionally -> ADD.
REQ-016 ADD: ADD_ctrl = LSB (combinational, same cycle); unconditionally -> SHIFT.
REQ-017 SHIFT: SRL_ctrl=1 for one cycle.
REQ-018 SHIFT with Count==WIDTH-1 -> DONE, Count unchanged.
REQ-019 SHIFT with any other Count -> ADD, Count incremented by 1.
REQ-020 DONE: Ready=1; Run=1 -> LOAD (Ready drops at that edge); otherwise stay in DONE.
REQ-021 W_ctrl, ADD_ctrl and SRL_ctrl SHALL be mutually exclusive; at most one is high in any cycle.
REQ-022 W_ctrl, ADD_ctrl and SRL_ctrl SHALL be 0 in IDLE and DONE.
REQ-023 Busy=1 exactly in LOAD, ADD and SHIFT; Ready=1 exactly in DONE.
REQ-024 Run SHALL be ignored in LOAD, ADD and SHIFT; no restart and no counter disturbance.
REQ-025 Latency: Ready rises 2*WIDTH+1 cycles after the edge that samples Run (65 cycles for WIDTH=32).
REQ-026 Per multiply: W_ctrl pulses exactly once; SRL_ctrl pulses exactly WIDTH times; ADD_ctrl is asserted once per ADD cycle in which LSB=1.
REQ-027 Count SHALL never exceed WIDTH-1; the counter never wraps.
REQ-028 An X or Z on LSB outside the ADD state SHALL NOT affect any output or state.

Reset
REQ-029 Reset=0 SHALL asynchronously force the state to IDLE and Count to 0, and drive W_ctrl, ADD_ctrl, SRL_ctrl, Busy and Ready to 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation; no further control pulses until a new Run after Reset=1.
REQ-031 The first rising edge after Reset deasserts SHALL evaluate from IDLE; Run high at that edge SHALL be accepted.

Verification
REQ-032 Reset=0 then released, Run=0 for 10 cycles -> all outputs 0, Count=0.
REQ-033 WIDTH=32, Run pulse, LSB driven from the bits of 0x0000000B -> W_ctrl 1 pulse; ADD_ctrl high in iterations 0, 1 and 3 only; 32 SRL_ctrl pulses; Ready rises 65 cycles after Run.
REQ-034 Run held high for the whole operation -> exactly one LOAD; on reaching DONE with Run still high, LOAD at the next edge and Ready high for one cycle.
REQ-035 Reset=0 asserted at iteration 10 (Count=10, state SHIFT) -> outputs 0 immediately (asynchronously), Count=0, no pulses until the next Run.
REQ-036 LSB held at 0 for the whole operation -> ADD_ctrl never asserted, 32 SRL_ctrl pulses, Ready asserted.
REQ-037 Run pulses while Busy -> ignored; SRL_ctrl pulse count and Ready timing identical to an undisturbed run.
